data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares the single-port data memory between the pipeline's MEM stage (CPU requester) and an external loader/DMA port (EXT requester). It uses fixed priority for the CPU plus a starvation counter that forces an EXT grant. Read data is routed back to its owner after a fixed memory latency through a tag pipeline. It sits between the MEM stage / loader and the data memory, and `cpu_stall` feeds the pipeline freeze logic.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `RD_LAT`, default 2: memory read latency in cycles, legal range 1..4.
- `MAX_WAIT`, default 3: consecutive EXT denial cycles before EXT is forced ahead of the CPU, legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: CPU access accepted this cycle.
- `cpu_stall` out 1: CPU request pending but denied (`cpu_req & ~cpu_gnt`).
- `cpu_rvalid` out 1: CPU read data valid this cycle.
- `cpu_rdata` out DATA_W: CPU read data.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_gnt`, `ext_rvalid`, `ext_rdata`: same meanings for the EXT requester.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid RD_LAT cycles after the sampling edge of a read.

## Operation
- At most one access is issued per cycle. Grant and `mem_*` are combinational from the requests and the registered state. Memory samples `mem_*` at the clock edge.
- **Arbitration:**
  - Only one requester active: that requester is granted.
  - Both active: CPU is granted, unless `wait_cnt == MAX_WAIT`, in which case EXT is granted.
  - Neither active: no grant, `mem_en = 0`, and `mem_we`/`mem_addr`/`mem_wdata` are 0.
- **Mux:** `mem_en = cpu_gnt | ext_gnt`. `mem_we`, `mem_addr` and `mem_wdata` come from the granted requester.
- **Starvation counter `wait_cnt`** (4-bit, saturating at MAX_WAIT):
  - Increments on each edge where `ext_req & ~ext_gnt`.
  - Clears to 0 on any edge where `ext_gnt = 1` or `ext_req = 0`.
  - Never exceeds MAX_WAIT.
- **Tag pipeline:** RD_LAT stages of {valid, owner}.
  - Stage 0 loads {`mem_en & ~mem_we`, `ext_gnt`} each edge; stages shift every edge.
  - The last stage drives routing:
    - `cpu_rvalid = valid & ~owner`.
    - `ext_rvalid = valid & owner`.
  - `cpu_rdata` and `ext_rdata` both equal `mem_rdata` when their rvalid is 1, and are 0 otherwise.
- Writes produce no rvalid. A grant completes a write at the sampling edge.
- Back-to-back reads from either or both requesters are fully pipelined: one read return per cycle, in issue order.

## Timing
- **Reset values:**
  - `wait_cnt = 0`; all tag stages invalid.
  - `cpu_rvalid = ext_rvalid = 0`; `cpu_rdata = ext_rdata = 0`.
  - With requests low: `cpu_gnt = ext_gnt = cpu_stall = 0` and `mem_en = 0`.
- **Grant latency:** zero cycles. The grant is asserted in the same cycle as the request when arbitration allows.
- **Read latency:** rvalid asserts exactly RD_LAT cycles after the cycle in which the read was granted.
- **Requester rules:** a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. Deasserting `req` without a grant is legal; no access is made.
- **Simultaneous events:**
  - A forced EXT grant with `cpu_req = 1` asserts `cpu_stall` for that cycle, and `wait_cnt` clears.
  - A read return and a new grant in the same cycle are independent.
- **Reset mid-operation:** in-flight reads are discarded and no rvalid is produced for them. Memory writes already sampled are not undone.
- **Worst case:**
  - Under continuous CPU requests, EXT waits at most MAX_WAIT cycles.
  - CPU stalls at most 1 cycle per forced EXT grant. EXT requests arriving back-to-back each restart the counter from 0.

## Test plan
- **Reset mid-read:** RD_LAT=2. Reset with CPU read of 0x0010 in flight → no `cpu_rvalid`. After reset: `mem_en = 0`, `wait_cnt = 0`, all outputs 0.
- **CPU-only reads:** CPU reads 0x0010 and 0x0011 in consecutive cycles; memory returns 0xAAAA and 0x5555 → `cpu_gnt` in both cycles, `cpu_rvalid` 2 cycles after each with 0xAAAA then 0x5555, `ext_rvalid` stays 0.
- **Starvation, MAX_WAIT=3:** `cpu_req` and `ext_req` held high continuously → `cpu_gnt` for 3 cycles, `ext_gnt` on the 4th with `cpu_stall = 1`, then the pattern repeats every 4 cycles.
- **Interleaved read routing:** EXT read of 0x0100 granted in cycle n, CPU read of 0x0020 in cycle n+1 → `ext_rvalid` at n+2 with data from 0x0100, `cpu_rvalid` at n+3; each requester's rvalid never asserts for the other's read.
- **Write then read:** CPU writes 0xBEEF to 0x0030, then reads 0x0030 on the next cycle → `mem_we = 1` then 0, no rvalid for the write, `cpu_rdata = 0xBEEF` 2 cycles after the read grant.
- **Counter clear:** EXT denied 2 cycles, drops `ext_req` for 1 cycle, re-requests with CPU busy → `wait_cnt` restarts from 0, and EXT is granted only after 3 further denials.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU MEM
// stage and an external loader/DMA port. The CPU has fixed priority, and a
// starvation counter forces an EXT grant. Read data returns through a
// {valid, owner} tag pipeline that matches the memory read latency.
//
// Handshake (both requesters): req/we/addr/wdata are held stable until gnt
// is seen. gnt is combinational in the same cycle as req, and the access
// completes at the rising edge that ends that cycle. A read returns exactly
// RD_LAT cycles later as a one-cycle rvalid pulse, with rdata valid only while
// rvalid is high. Dropping req before gnt is legal and makes no access.
module data_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Consecutive cycles in which EXT has asked and been refused.
  logic [3:0] wait_cnt;
  logic       force_ext;

  // Tag pipeline: bit i holds {valid, owner} for the read issued i+1 edges ago.
  // An owner bit of 1 marks a read issued by EXT.
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_owner;

  assign force_ext = (wait_cnt == MAX_WAIT_C);

  // Arbitration: the CPU wins ties unless EXT has waited MAX_WAIT cycles.
  always_comb begin
    cpu_gnt   = cpu_req & ~(ext_req & force_ext);
    ext_gnt   = ext_req & (~cpu_req | force_ext);
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Memory-side mux. The bus is driven to zero when nobody is granted.
  always_comb begin
    mem_en    = cpu_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Starvation counter: counts refused EXT cycles and saturates at MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (!ext_req || ext_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt < MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Tag shift register. Reset drops all in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= mem_en & ~mem_we;
      tag_owner[0] <= ext_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  // Return routing from the last tag stage. Data is gated to zero when not valid.
  always_comb begin
    cpu_rvalid = tag_valid[RD_LAT-1] & ~tag_owner[RD_LAT-1];
    ext_rvalid = tag_valid[RD_LAT-1] &  tag_owner[RD_LAT-1];
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ext_rdata  = ext_rvalid ? mem_rdata : '0;
  end

endmodule
